// File: rtl/cordic_pkg.sv
// cordic_pkg: shared types, mode constants and helpers for the CORDIC engine.
// Provides state encoding, angle table generator and saturation function.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  // atan(2^-i)/pi scaled by 2^30, then truncated to n_frac bits.
  function automatic int cordic_angle(input int i, input int n_frac);
    int t;
    case (i)
      0:       t = 268435456;
      1:       t = 158466703;
      2:       t = 83729453;
      3:       t = 42502377;
      4:       t = 21333746;
      5:       t = 10678952;
      6:       t = 5339924;
      7:       t = 2670138;
      default: t = 341782638 >>> i;
    endcase
    return t >>> (30 - n_frac);
  endfunction

  function automatic int sat(input int v, input int width);
    int hi;
    int lo;
    hi = (1 << (width - 1)) - 1;
    lo = -(1 << (width - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cordic_iterative_hs_microrot.sv
// cordic_microrot: one combinational CORDIC micro-rotation.
// Ports: x/y/z_i in, shift_i, angle_i, mode_i; x/y/z_o out (WI bits).
module cordic_microrot #(
  parameter int WI = 10,
  parameter int SW = 3
) (
  input  logic signed [WI-1:0] x_i,
  input  logic signed [WI-1:0] y_i,
  input  logic signed [WI-1:0] z_i,
  input  logic        [SW-1:0] shift_i,
  input  logic signed [WI-1:0] angle_i,
  input  logic                 mode_i,
  output logic signed [WI-1:0] x_o,
  output logic signed [WI-1:0] y_o,
  output logic signed [WI-1:0] z_o
);
  import cordic_pkg::*;

  logic signed [WI-1:0] xs;
  logic signed [WI-1:0] ys;
  logic                 pos;

  always_comb begin
    xs  = x_i >>> shift_i;
    ys  = y_i >>> shift_i;
    pos = (mode_i == MODE_VEC) ? y_i[WI-1] : ~z_i[WI-1];
    if (pos) begin
      x_o = x_i - ys;
      y_o = y_i + xs;
      z_o = z_i - angle_i;
    end else begin
      x_o = x_i + ys;
      y_o = y_i - xs;
      z_o = z_i + angle_i;
    end
  end

endmodule

// File: rtl/cordic_iterative_hs.sv
// cordic_iterative_hs: iterative rotation/vectoring CORDIC, valid/ready I/O.
// Ports: clk_i, rst_i, in_valid/ready, mode/x/y/z_i, out_valid/ready, x/y/z_o, busy_o.
module cordic_iterative_hs #(
  parameter int N_FRAC     = 7,
  parameter int ITERATIONS = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                mode_i,
  input  logic signed [N_FRAC:0] x_i,
  input  logic signed [N_FRAC:0] y_i,
  input  logic signed [N_FRAC:0] z_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic signed [N_FRAC:0] x_o,
  output logic signed [N_FRAC:0] y_o,
  output logic signed [N_FRAC:0] z_o,
  output logic                busy_o
);
  import cordic_pkg::*;

  localparam int W  = N_FRAC + 1;
  localparam int WI = W + 2;
  localparam int CW = $clog2(ITERATIONS);
  localparam logic signed [WI-1:0] H = WI'(1 << (N_FRAC - 1));

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [WI-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic                 mode_q, mode_d;
  logic signed [W-1:0]  xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;

  logic signed [WI-1:0] xe, ye, ze;
  logic signed [WI-1:0] px, py, pz;
  logic signed [WI-1:0] xn, yn, zn;
  logic signed [WI-1:0] ang_tab [ITERATIONS];

  for (genvar g = 0; g < ITERATIONS; g++) begin : g_ang
    assign ang_tab[g] = WI'(cordic_angle(g, N_FRAC));
  end

  assign xe = {{(WI-W){x_i[W-1]}}, x_i};
  assign ye = {{(WI-W){y_i[W-1]}}, y_i};
  assign ze = {{(WI-W){z_i[W-1]}}, z_i};

  // Fold the operand into the right half-plane (+/- pi/2 swap).
  always_comb begin
    px = xe;
    py = ye;
    pz = ze;
    if (mode_i == MODE_ROT) begin
      if (ze > H) begin
        px = -ye;
        py = xe;
        pz = ze - H;
      end else if (ze < -H) begin
        px = ye;
        py = -xe;
        pz = ze + H;
      end
    end else if (xe[WI-1]) begin
      if (!ye[WI-1]) begin
        px = ye;
        py = -xe;
        pz = ze + H;
      end else begin
        px = -ye;
        py = xe;
        pz = ze - H;
      end
    end
  end

  cordic_microrot #(
    .WI(WI),
    .SW(CW)
  ) u_rot (
    .x_i    (x_q),
    .y_i    (y_q),
    .z_i    (z_q),
    .shift_i(cnt_q),
    .angle_i(ang_tab[cnt_q]),
    .mode_i (mode_q),
    .x_o    (xn),
    .y_o    (yn),
    .z_o    (zn)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    mode_d  = mode_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    zo_d    = zo_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          x_d     = px;
          y_d     = py;
          z_d     = pz;
          mode_d  = mode_i;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        x_d = xn;
        y_d = yn;
        z_d = zn;
        if (cnt_q == CW'(ITERATIONS - 1)) begin
          xo_d    = W'(sat(int'(xn), W));
          yo_d    = W'(sat(int'(yn), W));
          zo_d    = W'(sat(int'(zn), W));
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      mode_q  <= MODE_ROT;
      xo_q    <= '0;
      yo_q    <= '0;
      zo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      mode_q  <= mode_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      zo_q    <= zo_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign x_o         = xo_q;
  assign y_o         = yo_q;
  assign z_o         = zo_q;

endmodule

// File: tb/tb_cordic_iterative_hs.sv
// tb_cordic_iterative_hs: directed + random checks of the iterative CORDIC.
// Reference is an integer CORDIC model built from the algorithm definition.
module tb_cordic_iterative_hs;

  localparam int NF = 7;
  localparam int IT = 6;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic              mode_i;
  logic signed [7:0] x_i, y_i, z_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic signed [7:0] x_o, y_o, z_o;
  logic              busy_o;

  int ncmp = 0;
  int nerr = 0;
  int atab [IT] = '{32, 18, 9, 5, 2, 1};

  cordic_iterative_hs #(
    .N_FRAC    (NF),
    .ITERATIONS(IT)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .mode_i     (mode_i),
    .x_i        (x_i),
    .y_i        (y_i),
    .z_i        (z_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .x_o        (x_o),
    .y_o        (y_o),
    .z_o        (z_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int clampv(input int v);
    return (v > 127) ? 127 : ((v < -128) ? -128 : v);
  endfunction

  task automatic model(input logic m, input int x, input int y,
                       input int z, output int ex, output int ey,
                       output int ez);
    int t;
    int d;
    if (m == 1'b0) begin
      if (z > 64) begin
        t = x; x = -y; y = t; z = z - 64;
      end else if (z < -64) begin
        t = x; x = y; y = -t; z = z + 64;
      end
    end else if (x < 0) begin
      if (y >= 0) begin
        t = x; x = y; y = -t; z = z + 64;
      end else begin
        t = x; x = -y; y = t; z = z - 64;
      end
    end
    for (int i = 0; i < IT; i++) begin
      d = ((m == 1'b0 && z >= 0) || (m == 1'b1 && y < 0)) ? 1 : -1;
      t = x - d * (y >>> i);
      y = y + d * (x >>> i);
      x = t;
      z = z - d * atab[i];
    end
    ex = clampv(x);
    ey = clampv(y);
    ez = clampv(z);
  endtask

  task automatic check(input string tag, input int got, input int exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_near(input string tag, input int got,
                            input int exp, input int tol);
    ncmp++;
    assert ((got - exp) <= tol && (exp - got) <= tol) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d +/-%0d",
             tag, got, exp, tol);
    end
  endtask

  task automatic do_op(input string tag, input logic m, input int x,
                       input int y, input int z, output int rx,
                       output int ry, output int rz);
    int ex, ey, ez, lat;
    check({tag, "/in_ready"}, int'(in_ready_o), 1);
    mode_i     = m;
    x_i        = x[7:0];
    y_i        = y[7:0];
    z_i        = z[7:0];
    in_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    lat = 1;
    while (!out_valid_o && lat < 40) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    check({tag, "/latency"}, lat, IT + 1);
    rx = int'(x_o);
    ry = int'(y_o);
    rz = int'(z_o);
    model(m, x, y, z, ex, ey, ez);
    check({tag, "/x"}, rx, ex);
    check({tag, "/y"}, ry, ey);
    check({tag, "/z"}, rz, ez);
  endtask

  task automatic consume(input string tag);
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b0;
    check({tag, "/idle_busy"}, int'(busy_o), 0);
    check({tag, "/idle_valid"}, int'(out_valid_o), 0);
  endtask

  initial begin
    int rx, ry, rz, hx;
    int m, x, y, z, hold;
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    mode_i      = 1'b0;
    x_i         = '0;
    y_i         = '0;
    z_i         = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst/in_ready", int'(in_ready_o), 1);
    check("rst/out_valid", int'(out_valid_o), 0);
    check("rst/busy", int'(busy_o), 0);
    check("rst/x_o", int'(x_o), 0);
    check("rst/z_o", int'(z_o), 0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    do_op("rot45", 1'b0, 77, 0, 32, rx, ry, rz);
    check_near("rot45/xn", rx, 90, 3);
    check_near("rot45/yn", ry, 90, 3);
    check_near("rot45/zn", rz, 0, 2);
    consume("rot45");

    do_op("vec45", 1'b1, 40, 40, 0, rx, ry, rz);
    check_near("vec45/xn", rx, 93, 3);
    check_near("vec45/yn", ry, 0, 3);
    check_near("vec45/zn", rz, 32, 2);
    consume("vec45");

    do_op("rot135", 1'b0, 77, 0, 96, rx, ry, rz);
    check_near("rot135/xn", rx, -90, 3);
    check_near("rot135/yn", ry, 90, 3);
    consume("rot135");

    do_op("vecq2", 1'b1, -40, 40, 0, rx, ry, rz);
    check_near("vecq2/zn", rz, 96, 3);
    consume("vecq2");

    do_op("vecsat", 1'b1, 64, 64, 0, rx, ry, rz);
    check("vecsat/x127", rx, 127);
    hx = rx;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        mode_i = 1'b0; x_i = 8'sd5; y_i = 8'sd5; z_i = 8'sd5;
        in_valid_i = 1'b1;
      end else begin
        in_valid_i = 1'b0;
      end
      @(posedge clk_i);
      #1;
      check("bp/valid", int'(out_valid_o), 1);
      check("bp/in_ready", int'(in_ready_o), 0);
      check("bp/x_stable", int'(x_o), hx);
      check("bp/y_stable", int'(y_o), ry);
    end
    in_valid_i = 1'b0;
    consume("bp");
    check("bp/in_ready_after", int'(in_ready_o), 1);
    do_op("bp_next", 1'b1, 40, 40, 0, rx, ry, rz);
    consume("bp_next");

    mode_i = 1'b0; x_i = 8'sd77; y_i = 8'sd0; z_i = 8'sd32;
    in_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    check("midrst/valid", int'(out_valid_o), 0);
    check("midrst/busy", int'(busy_o), 0);
    check("midrst/x_o", int'(x_o), 0);
    check("midrst/y_o", int'(y_o), 0);
    check("midrst/z_o", int'(z_o), 0);
    #3;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("midrst/in_ready", int'(in_ready_o), 1);
    do_op("post_rst", 1'b0, 77, 0, 32, rx, ry, rz);
    check_near("post_rst/xn", rx, 90, 3);
    check_near("post_rst/yn", ry, 90, 3);
    consume("post_rst");

    for (int n = 0; n < 40; n++) begin
      m    = int'($urandom_range(0, 1));
      x    = int'($urandom_range(0, 255)) - 128;
      y    = int'($urandom_range(0, 255)) - 128;
      z    = int'($urandom_range(0, 255)) - 128;
      hold = int'($urandom_range(0, 3));
      do_op($sformatf("rnd%0d", n), m[0], x, y, z, rx, ry, rz);
      repeat (hold) @(posedge clk_i);
      #1;
      consume($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
